// File: rtl/move_list_sequencer.sv
// rtl/move_list_sequencer.sv - sequences one LMG run: launch, drain FIFO into move RAM, arbitrate with Avalon writes
module move_list_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 15,
    parameter int BASE_ADDR   = 16,
    parameter int MAX_ENTRIES = 32752
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [ADDR_WIDTH-1:0] o_move_count,
    output logic                  o_lmg_start,
    input  logic                  i_lmg_done,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_q,
    output logic                  o_fifo_rdreq,
    input  logic                  i_av_wr_req,
    input  logic [ADDR_WIDTH-1:0] i_av_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_av_wr_data,
    output logic                  o_ram_wren,
    output logic [ADDR_WIDTH-1:0] o_ram_wraddr,
    output logic [DATA_WIDTH-1:0] o_ram_data
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] L_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] L_MAX  = ADDR_WIDTH'(MAX_ENTRIES);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_overflow;
    logic                    r_lmg_start;
    logic                    r_done_latch;
    logic [ADDR_WIDTH-1:0]   r_move_count;

    logic                    w_room;
    logic                    w_drain_pop;
    logic                    w_flush;
    logic                    w_seq_wr;

    // Avalon has priority: a pending slave write stalls the drain for that cycle
    assign w_room       = (r_move_count < L_MAX);
    assign w_drain_pop  = (r_state == S_DRAIN) && !i_fifo_empty && !i_av_wr_req && !i_reset;
    assign w_flush      = (r_state == S_IDLE) && !i_fifo_empty && !i_reset;
    assign w_seq_wr     = w_drain_pop && w_room;

    assign o_fifo_rdreq = w_flush || w_drain_pop;
    assign o_ram_wren   = !i_reset && (i_av_wr_req || w_seq_wr);
    assign o_ram_wraddr = i_av_wr_req ? i_av_wr_addr : (L_BASE + r_move_count);
    assign o_ram_data   = i_av_wr_req ? i_av_wr_data : i_fifo_q;

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_overflow   = r_overflow;
    assign o_move_count = r_move_count;
    assign o_lmg_start  = r_lmg_start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start && i_fifo_empty) w_next = S_LAUNCH;
            S_LAUNCH: w_next = i_start ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
                if (!i_start)
                    w_next = S_IDLE;
                else if (i_fifo_empty && (r_done_latch || i_lmg_done))
                    w_next = S_DONE;
            end
            S_DONE:   if (!i_start) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Status flags are derived from the next state so they line up with the state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_lmg_start  <= 1'b0;
            r_done_latch <= 1'b0;
            r_move_count <= '0;
        end else begin
            r_state     <= w_next;
            r_busy      <= (w_next == S_LAUNCH) || (w_next == S_DRAIN);
            r_lmg_start <= (w_next == S_LAUNCH);
            r_done      <= (w_next == S_DONE);
            if (r_state == S_IDLE && w_next == S_LAUNCH) begin
                r_move_count <= '0;
                r_overflow   <= 1'b0;
                r_done_latch <= 1'b0;
            end
            if (r_state == S_DRAIN && i_lmg_done)
                r_done_latch <= 1'b1;
            if (w_seq_wr)
                r_move_count <= r_move_count + ADDR_WIDTH'(1);
            if (w_drain_pop && !w_room)
                r_overflow <= 1'b1;
        end
    end

endmodule
